syn_current_8b: RTL and testbench
=================================

# syn_current_8b

Synaptic current stage for the 8-bit neuron datapath. It sits directly upstream of the 8-bit neuron membrane block and produces that block's signed `I_syn` input. Each cycle it leaks the stored current toward zero, then adds the programmable signed weights of the spike inputs that are asserted. The result is saturated to 8-bit signed.

## Interface

Parameters:
- `N_IN`, default 4: number of presynaptic spike inputs (2..16).
- `DECAY_SHIFT`, default 3: leak rate; decay term is `I_syn >>> DECAY_SHIFT`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-high (asserted = 1), sampled on `clk` rising edge.
- `en`  in  1  update enable; 0 freezes the current and flags.
- `spike_in`  in  N_IN  one bit per synapse, sampled each enabled cycle.
- `w_wr_en`  in  1  weight write strobe.
- `w_wr_addr`  in  clog2(N_IN)  weight index to write.
- `w_wr_data`  in  8  signed weight value.
- `I_syn`  out  8  signed synaptic current, registered; feeds the neuron's `I_syn`.
- `sat_flag`  out  1  high for the cycle after an update that clipped.
- `I_valid`  out  1  high from the first enabled update after reset onward.

## Operation

- State:
  - weight file `w[0..N_IN-1]` (8-bit signed each);
  - current register `I` (8-bit signed);
  - `sat_flag` and `I_valid` registers.
- Reset (`rst_n`=1 at a clock edge):
  - `I`=0, all weights=0, `sat_flag`=0, `I_valid`=0.
  - Reset overrides `en` and `w_wr_en` in the same cycle.
- Decay term `d`:
  - `d = I >>> DECAY_SHIFT` (arithmetic shift, floor).
  - If `d`==0 and `I`>0, force `d`=1, so positive currents reach 0.
  - Negative `I` needs no correction; floor gives `d`≤-1, e.g. -1 → 0.
- Accumulate: `S` = sum of `w[k]` over all k with `spike_in[k]`=1.
- Update when `en`=1:
  - Compute `T = I - d + S` at full width, at least 8+clog2(N_IN)+2 bits, signed.
  - `I` ← clamp(T, -128, +127).
  - `sat_flag` ← 1 if clamping occurred, else 0.
  - `I_valid` ← 1.
- When `en`=0:
  - `I` and `I_valid` hold.
  - `sat_flag` ← 0.
- Weight write:
  - On `w_wr_en`=1, `w[w_wr_addr]` ← `w_wr_data`, independent of `en`.
  - Addresses ≥ N_IN are ignored.
- Write/spike collision: when the same cycle writes `w[k]` and has `spike_in[k]`=1, the update uses the old `w[k]`. The new value takes effect from the next cycle.
- No FSM beyond the valid flag: states RESET (`I_valid`=0) → RUN (`I_valid`=1) on the first enabled cycle. The block returns to RESET only through `rst_n`.

## Timing

- Latency: a spike sampled at edge n is reflected in `I_syn` after edge n (1 cycle, registered output).
- Path from `I_syn` to `w` has no combinational dependence. All outputs are register outputs.
- Reset mid-operation: the next cycle shows `I_syn`=0 and `sat_flag`=0. Weights are lost and must be reprogrammed.
- Throughput: one update per clock when `en`=1.
- Multiple simultaneous spikes are summed in the same cycle. The sum is clamped only after adding, never per term.

## Test plan

- **Reset:** hold `rst_n`=1 for 2 cycles with spikes toggling and writes active → `I_syn`=0, `sat_flag`=0, `I_valid`=0, weights all 0. Verify the weights by spiking all inputs after release: `I_syn` stays 0.
- **Single spike and decay** (`DECAY_SHIFT`=3): write `w[0]`=20, then pulse `spike_in[0]` for one cycle → `I_syn` = 20, 18, 16, 14, 13, 12, 11, 10, 9, 8, 7, 6, … 1, 0, then holds 0. Negative case: `w[1]`=-20 gives -20, -17, -14, …, -1, 0.
- **Saturation:** `w[0]`=`w[1]`=100, spike both → `I_syn`=127, `sat_flag`=1 for one cycle. With `w`=-100 on both inputs → `I_syn`=-128, `sat_flag`=1.
- **Collision:** `w[2]`=10; in one cycle write `w[2]`=50 with `spike_in[2]`=1 → `I_syn`=10. Spiking again next cycle → 10-1+50 = 59.
- **Enable freeze:** `I_syn`=40, then `en`=0 for 5 cycles with spikes present → `I_syn` stays 40 and `sat_flag`=0. Re-enabling with no spikes → 35.
- **Mid-run reset:** assert `rst_n` while `I_syn`=90 → `I_syn`=0 the next cycle and `I_valid`=0. After the first enabled cycle `I_valid`=1.

Source files
------------

// File: rtl/syn_current_8b.sv
// syn_current_8b: synaptic current stage feeding the 8-bit neuron membrane block.
// Each enabled cycle the stored current leaks toward zero, the weights of the
// asserted spike inputs are added, and the result is saturated to 8-bit signed.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH (name kept for neuron-datapath compatibility)
//   en         update enable; 0 freezes current and valid, clears sat_flag
//   spike_in   one spike bit per synapse
//   w_wr_en    weight write strobe (independent of en)
//   w_wr_addr  weight index to write; indices >= N_IN are ignored
//   w_wr_data  signed 8-bit weight
//   I_syn      registered signed synaptic current
//   sat_flag   high for the cycle after an update that clipped
//   I_valid    high from the first enabled update after reset onward
module syn_current_8b #(
    parameter int unsigned N_IN        = 4,
    parameter int unsigned DECAY_SHIFT = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    en,
    input  logic [N_IN-1:0]                         spike_in,
    input  logic                                    w_wr_en,
    input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] w_wr_addr,
    input  logic [7:0]                              w_wr_data,
    output logic [7:0]                              I_syn,
    output logic                                    sat_flag,
    output logic                                    I_valid
);

    localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    // Wide enough that leak plus the sum of all weights can never wrap.
    localparam int unsigned TW = 8 + AW + 2;

    localparam logic signed [TW-1:0] T_MAX = TW'(127);
    localparam logic signed [TW-1:0] T_MIN = TW'(-128);

    logic signed [7:0]    w_q [N_IN];
    logic signed [7:0]    i_q;
    logic                 sat_q;
    logic                 valid_q;

    logic signed [7:0]    d_c;
    logic signed [TW-1:0] sum_c;
    logic signed [TW-1:0] t_c;
    logic signed [7:0]    i_d;
    logic                 sat_d;

    // Leak term; positive currents always lose at least 1 so they reach zero.
    always_comb begin
        d_c = i_q >>> DECAY_SHIFT;
        if (d_c == 8'sd0 && i_q > 8'sd0) begin
            d_c = 8'sd1;
        end
    end

    // Sum of active weights at full width, clamped only once after adding.
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            if (spike_in[k]) begin
                sum_c = sum_c + TW'(w_q[k]);
            end
        end
        t_c   = TW'(i_q) - TW'(d_c) + sum_c;
        i_d   = t_c[7:0];
        sat_d = 1'b0;
        if (t_c > T_MAX) begin
            i_d   = 8'sd127;
            sat_d = 1'b1;
        end else if (t_c < T_MIN) begin
            i_d   = -8'sd128;
            sat_d = 1'b1;
        end
    end

    // Current, flags and weight file. Weights are written after the update
    // reads them, so a same-cycle write/spike uses the old weight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            i_q     <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int k = 0; k < int'(N_IN); k++) begin
                w_q[k] <= '0;
            end
        end else begin
            if (en) begin
                i_q     <= i_d;
                sat_q   <= sat_d;
                valid_q <= 1'b1;
            end else begin
                sat_q   <= 1'b0;
            end
            for (int k = 0; k < int'(N_IN); k++) begin
                if (w_wr_en && w_wr_addr == AW'(k)) begin
                    w_q[k] <= w_wr_data;
                end
            end
        end
    end

    assign I_syn    = i_q;
    assign sat_flag = sat_q;
    assign I_valid  = valid_q;

endmodule

// File: tb/tb_syn_current_8b.sv
// Testbench for syn_current_8b: directed table of test-plan sequences with
// hand-derived expectations, followed by random stimulus against an
// integer-arithmetic reference model.
module tb_syn_current_8b;

    localparam int N  = 4;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] spike_in;
    logic       w_wr_en;
    logic [1:0] w_wr_addr;
    logic [7:0] w_wr_data;
    logic [7:0] I_syn;
    logic       sat_flag;
    logic       I_valid;

    syn_current_8b #(.N_IN(N), .DECAY_SHIFT(DS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .spike_in (spike_in),
        .w_wr_en  (w_wr_en),
        .w_wr_addr(w_wr_addr),
        .w_wr_data(w_wr_data),
        .I_syn    (I_syn),
        .sat_flag (sat_flag),
        .I_valid  (I_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: plain integers.
    int mw [N];
    int mi;
    int ms;
    int mv;

    typedef struct {
        bit       rst;
        bit       en;
        bit [3:0] spk;
        bit       wr;
        bit [1:0] addr;
        int       data;
        int       ei;
        int       es;
        int       ev;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit e, bit [3:0] spk, bit wr, bit [1:0] addr,
                                int data, int ei, int es, int ev);
        vec_t v;
        v.rst = rst; v.en = e; v.spk = spk; v.wr = wr; v.addr = addr;
        v.data = data; v.ei = ei; v.es = es; v.ev = ev;
        return v;
    endfunction

    // Floor division by 2^DS.
    function automatic int floor_div(int x);
        int p;
        p = 1 << DS;
        if (x >= 0) return x / p;
        return -((-x + p - 1) / p);
    endfunction

    task automatic model_step(bit rst, bit e, bit [3:0] spk, bit wr, bit [1:0] addr, int data);
        int d;
        int s;
        int t;
        int wd;
        if (rst) begin
            for (int k = 0; k < N; k++) mw[k] = 0;
            mi = 0; ms = 0; mv = 0;
            return;
        end
        if (e) begin
            d = floor_div(mi);
            if (d == 0 && mi > 0) d = 1;
            s = 0;
            for (int k = 0; k < N; k++) if (spk[k]) s += mw[k];
            t = mi - d + s;
            ms = 0;
            if (t > 127)  begin t = 127;  ms = 1; end
            if (t < -128) begin t = -128; ms = 1; end
            mi = t;
            mv = 1;
        end else begin
            ms = 0;
        end
        if (wr) begin
            wd = data & 255;
            if (wd > 127) wd -= 256;
            mw[addr] = wd;
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    int dut_i;

    // One clock: drive, clock, update model, then compare against the model.
    task automatic apply(bit rst, bit e, bit [3:0] spk, bit wr, bit [1:0] addr, int data);
        rst_n     = rst;
        en        = e;
        spike_in  = spk;
        w_wr_en   = wr;
        w_wr_addr = addr;
        w_wr_data = 8'(data);
        @(posedge clk);
        model_step(rst, e, spk, wr, addr, data);
        #1;
        dut_i = int'($signed(I_syn));
        check("model_I_syn",    dut_i,         mi);
        check("model_sat_flag", int'(sat_flag), ms);
        check("model_I_valid",  int'(I_valid),  mv);
    endtask

    initial begin
        int pos_dec[$];
        int neg_dec[$];
        pos_dec = '{18, 16, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
        neg_dec = '{-17, -14, -12, -10, -8, -7, -6, -5, -4, -3, -2, -1, 0, 0};

        // Reset with spikes and writes active; weights must stay zero.
        tbl.push_back(mk(1, 1, 4'b1111, 1, 0, 55, 0, 0, 0));
        tbl.push_back(mk(1, 1, 4'b0101, 1, 1, -3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 0, 0, 1));
        // Single positive spike and decay.
        tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 20, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 20, 0, 1));
        foreach (pos_dec[j]) tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, pos_dec[j], 0, 1));
        // Negative spike and decay.
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, -20, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 0, -20, 0, 1));
        foreach (neg_dec[j]) tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, neg_dec[j], 0, 1));
        // Positive saturation, then negative saturation.
        tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 100, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 100, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0011, 0, 0, 0, 127, 1, 1));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 112, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 0, -100, 112, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, -100, 112, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0011, 0, 0, 0, -102, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0011, 0, 0, 0, -128, 1, 1));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, -112, 0, 1));
        // Write/spike collision uses the old weight.
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 2, 10, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, 1, 2, 50, 10, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0100, 0, 0, 0, 59, 0, 1));
        // Enable freeze.
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 3, 40, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1000, 0, 0, 0, 40, 0, 1));
        for (int j = 0; j < 5; j++) tbl.push_back(mk(0, 0, 4'b1111, 0, 0, 0, 40, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 35, 0, 1));
        // Mid-run reset from 90.
        tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 59, 35, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 90, 0, 1));
        tbl.push_back(mk(1, 1, 4'b1111, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 0, 0, 1));

        for (int k = 0; k < N; k++) mw[k] = 0;
        mi = 0; ms = 0; mv = 0;

        foreach (tbl[j]) begin
            apply(tbl[j].rst, tbl[j].en, tbl[j].spk, tbl[j].wr, tbl[j].addr, tbl[j].data);
            check($sformatf("vec%0d_I_syn", j),    dut_i,           tbl[j].ei);
            check($sformatf("vec%0d_sat_flag", j), int'(sat_flag),  tbl[j].es);
            check($sformatf("vec%0d_I_valid", j),  int'(I_valid),   tbl[j].ev);
        end

        // Random stimulus against the reference model.
        for (int j = 0; j < 600; j++) begin
            apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0),
                  4'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom),
                  $urandom_range(0, 255) - 128);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
